eva_intr_collector: RTL and testbench

Parametrised interrupt collector for the EVA testbench, successor to the fixed 32-bit rising-edge interrupt tap. It captures per-channel interrupt events in edge or level mode, with masking, and holds a pending bit per channel that software clears by acknowledge. Each event is queued with a cycle timestamp in a FIFO drained over a valid/ready port toward the DPI/software side. FIFO overflow is counted, not silently lost.

---
 rtl/eva_intr_pkg.sv | 13 +
 rtl/eva_sync_fifo.sv | 52 +++++
 rtl/eva_intr_collector.sv | 75 +++++++
 tb/tb_eva_intr_collector.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/eva_intr_pkg.sv
// Shared constants and helpers for the EVA interrupt collector.
package eva_intr_pkg;

    localparam int   EVA_INTR_MAX   = 64;
    localparam int   OVF_W          = 16;
    localparam logic EVA_INTR_EDGE  = 1'b0;
    localparam logic EVA_INTR_LEVEL = 1'b1;

    function automatic logic [OVF_W-1:0] sat_inc16(input logic [OVF_W-1:0] v);
        return (v == '1) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/eva_sync_fifo.sv
// First-word-fall-through synchronous FIFO; a pop frees a slot for a same-cycle push when full.
module eva_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                   aclk,
    input  logic                   arest_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       din,
    input  logic                   pop,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [AW-1:0]               wr_ptr;
    logic [AW-1:0]               rd_ptr;
    logic                        wr_en;
    logic                        rd_en;

    assign empty = (level == '0);
    assign full  = (level == (AW+1)'(DEPTH));
    assign rd_en = pop & ~empty;
    assign wr_en = push & (~full | rd_en);
    // Head is forced to zero while empty so stale storage never leaks out.
    assign dout  = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge aclk) begin
        if (wr_en) mem[wr_ptr] <= din;
    end

    always_ff @(posedge aclk or negedge arest_n) begin
        if (!arest_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/eva_intr_collector.sv
// Interrupt collector: edge/level capture, pending bits with ack, timestamped event FIFO.
module eva_intr_collector
    import eva_intr_pkg::*;
#(
    parameter int NUM_INTR   = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int TS_W       = 32
) (
    input  logic                        aclk,
    input  logic                        arest_n,
    input  logic [NUM_INTR-1:0]         intr_in,
    input  logic [NUM_INTR-1:0]         intr_mask,
    input  logic [NUM_INTR-1:0]         level_mode,
    input  logic                        ack_valid,
    input  logic [NUM_INTR-1:0]         ack_vec,
    output logic                        evt_valid,
    input  logic                        evt_ready,
    output logic [NUM_INTR-1:0]         evt_vec,
    output logic [TS_W-1:0]             evt_ts,
    output logic [NUM_INTR-1:0]         pending,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic [OVF_W-1:0]            ovf_cnt
);

    logic [NUM_INTR-1:0] intr_ff;
    logic [NUM_INTR-1:0] rise;
    logic [NUM_INTR-1:0] trig;
    logic [NUM_INTR-1:0] ack_clr;
    logic [TS_W-1:0]     ts;
    logic                push;
    logic                pop;
    logic                full;
    logic                empty;
    logic                drop;

    assign rise = intr_in & ~intr_ff;
    // Level channels fire only while not already pending, so an ack re-arms them.
    assign trig = intr_mask & ((~level_mode & rise) | (level_mode & intr_in & ~pending));
    assign ack_clr = ack_valid ? (ack_vec & ~trig) : '0;

    assign push      = |trig;
    assign evt_valid = ~empty;
    assign pop       = evt_valid & evt_ready;
    assign drop      = push & full & ~pop;

    always_ff @(posedge aclk or negedge arest_n) begin
        if (!arest_n) begin
            intr_ff <= '0;
            pending <= '0;
            ts      <= '0;
            ovf_cnt <= '0;
        end else begin
            intr_ff <= intr_in;
            pending <= (pending | trig) & ~ack_clr;
            ts      <= ts + 1'b1;
            if (drop) ovf_cnt <= sat_inc16(ovf_cnt);
        end
    end

    eva_sync_fifo #(
        .WIDTH (NUM_INTR + TS_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .aclk    (aclk),
        .arest_n (arest_n),
        .push    (push),
        .din     ({trig, ts}),
        .pop     (pop),
        .dout    ({evt_vec, evt_ts}),
        .full    (full),
        .empty   (empty),
        .level   (fifo_level)
    );

endmodule

// File: tb/tb_eva_intr_collector.sv
// Directed bench for eva_intr_collector with a 4-entry FIFO.
module tb_eva_intr_collector;

    localparam int NI = 32;
    localparam int FD = 4;
    localparam int TW = 32;

    logic          aclk;
    logic          arest_n;
    logic [NI-1:0] intr_in;
    logic [NI-1:0] intr_mask;
    logic [NI-1:0] level_mode;
    logic          ack_valid;
    logic [NI-1:0] ack_vec;
    logic          evt_valid;
    logic          evt_ready;
    logic [NI-1:0] evt_vec;
    logic [TW-1:0] evt_ts;
    logic [NI-1:0] pending;
    logic [2:0]    fifo_level;
    logic [15:0]   ovf_cnt;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    eva_intr_collector #(.NUM_INTR(NI), .FIFO_DEPTH(FD), .TS_W(TW)) dut (
        .aclk       (aclk),
        .arest_n    (arest_n),
        .intr_in    (intr_in),
        .intr_mask  (intr_mask),
        .level_mode (level_mode),
        .ack_valid  (ack_valid),
        .ack_vec    (ack_vec),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_vec    (evt_vec),
        .evt_ts     (evt_ts),
        .pending    (pending),
        .fifo_level (fifo_level),
        .ovf_cnt    (ovf_cnt)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // cyc = number of active edges since reset release; inputs set now are sampled at edge cyc.
    task automatic tick();
        @(posedge aclk);
        cyc++;
        @(negedge aclk);
    endtask

    task automatic tick_to(input int n);
        while (cyc < n) tick();
    endtask

    task automatic chk_head(input string tag, input logic [NI-1:0] v, input logic [TW-1:0] t);
        chk({tag, "_valid"}, 64'(evt_valid), 64'(1));
        chk({tag, "_vec"}, 64'(evt_vec), 64'(v));
        chk({tag, "_ts"}, 64'(evt_ts), 64'(t));
    endtask

    initial begin
        arest_n    = 1'b0;
        intr_in    = '0;
        intr_mask  = '1;
        level_mode = '0;
        ack_valid  = 1'b0;
        ack_vec    = '0;
        evt_ready  = 1'b0;
        repeat (3) @(negedge aclk);

        chk("rst_valid", 64'(evt_valid), 64'(0));
        chk("rst_level", 64'(fifo_level), 64'(0));
        chk("rst_pending", 64'(pending), 64'(0));
        chk("rst_ovf", 64'(ovf_cnt), 64'(0));
        chk("rst_vec", 64'(evt_vec), 64'(0));
        chk("rst_ts", 64'(evt_ts), 64'(0));
        arest_n = 1'b1;
        cyc = 0;

        // Edge, single channel at cycle 10
        tick_to(10);
        intr_in = 32'h8;
        tick();
        chk_head("edge", 32'h8, 32'd10);
        chk("edge_pending", 64'(pending), 64'h8);
        chk("edge_level", 64'(fifo_level), 64'(1));
        tick_to(14);
        chk("edge_hold_level", 64'(fifo_level), 64'(1));
        evt_ready = 1'b1;
        tick();
        chk("edge_drain_valid", 64'(evt_valid), 64'(0));
        chk("edge_drain_vec", 64'(evt_vec), 64'(0));
        evt_ready = 1'b0;
        ack_valid = 1'b1; ack_vec = 32'h8;
        tick();
        ack_valid = 1'b0; ack_vec = '0;
        chk("edge_ack_pending", 64'(pending), 64'(0));
        chk("edge_ack_no_refire", 64'(fifo_level), 64'(0));
        intr_in = '0;

        // Level re-fire after ack at cycle 20
        level_mode = 32'h20;
        intr_in    = 32'h20;
        tick();
        chk("lvl_pending", 64'(pending), 64'h20);
        tick_to(20);
        chk("lvl_no_refire", 64'(fifo_level), 64'(1));
        ack_valid = 1'b1; ack_vec = 32'h20;
        tick();
        ack_valid = 1'b0; ack_vec = '0;
        chk("lvl_ack_pending", 64'(pending), 64'(0));
        chk("lvl_ack_level", 64'(fifo_level), 64'(1));
        tick();
        chk("lvl_refire_pending", 64'(pending), 64'h20);
        chk("lvl_refire_level", 64'(fifo_level), 64'(2));
        evt_ready = 1'b1;
        chk_head("lvl_rec0", 32'h20, 32'd16);
        tick();
        chk_head("lvl_rec1", 32'h20, 32'd21);
        tick();
        chk("lvl_drained", 64'(evt_valid), 64'(0));
        evt_ready  = 1'b0;
        intr_in    = '0;
        level_mode = '0;
        ack_valid  = 1'b1; ack_vec = 32'h20;
        tick();
        ack_valid = 1'b0; ack_vec = '0;
        chk("lvl_clear", 64'(pending), 64'(0));

        // Rise and ack on the same bit in the same cycle: set wins
        intr_in   = 32'h1;
        ack_valid = 1'b1; ack_vec = 32'h1;
        tick();
        ack_valid = 1'b0; ack_vec = '0;
        intr_in   = '0;
        chk("coll_pending", 64'(pending), 64'h1);
        chk_head("coll", 32'h1, 32'd25);
        evt_ready = 1'b1;
        ack_valid = 1'b1; ack_vec = 32'h1;
        tick();
        evt_ready = 1'b0;
        ack_valid = 1'b0; ack_vec = '0;
        chk("coll_drained", 64'(fifo_level), 64'(0));

        // Overflow: six events into a 4-deep FIFO, stalled consumer
        for (int i = 0; i < 6; i++) begin
            intr_in = 32'h2;
            tick();
            intr_in = '0;
            tick();
        end
        chk("ovf_level", 64'(fifo_level), 64'(4));
        chk("ovf_cnt", 64'(ovf_cnt), 64'(2));
        chk("ovf_pending", 64'(pending), 64'h2);

        // Full with simultaneous pop and push
        intr_in   = 32'h2;
        evt_ready = 1'b1;
        chk_head("ovf_rec0", 32'h2, 32'd27);
        tick();
        intr_in = '0;
        chk("fullpop_level", 64'(fifo_level), 64'(4));
        chk("fullpop_ovf", 64'(ovf_cnt), 64'(2));
        chk_head("ovf_rec1", 32'h2, 32'd29);
        tick();
        chk_head("ovf_rec2", 32'h2, 32'd31);
        tick();
        chk_head("ovf_rec3", 32'h2, 32'd33);
        tick();
        chk_head("fullpop_rec", 32'h2, 32'd39);
        tick();
        chk("ovf_drained", 64'(evt_valid), 64'(0));
        evt_ready = 1'b0;

        // Masked channel: no trigger, pending still clearable by ack
        intr_mask = ~32'h82;
        intr_in   = 32'h80;
        ack_valid = 1'b1; ack_vec = 32'h2;
        tick();
        ack_valid = 1'b0; ack_vec = '0;
        chk("mask_level", 64'(fifo_level), 64'(0));
        chk("mask_pending", 64'(pending), 64'(0));
        intr_mask = '1;
        intr_in   = '0;

        // Reset mid-stream with three records queued
        for (int i = 0; i < 3; i++) begin
            intr_in = 32'h1;
            tick();
            intr_in = '0;
            tick();
        end
        chk("rst_mid_pre_level", 64'(fifo_level), 64'(3));
        #2 arest_n = 1'b0;
        #1;
        chk("rst_mid_valid", 64'(evt_valid), 64'(0));
        chk("rst_mid_level", 64'(fifo_level), 64'(0));
        chk("rst_mid_ovf", 64'(ovf_cnt), 64'(0));
        chk("rst_mid_vec", 64'(evt_vec), 64'(0));
        @(negedge aclk);
        arest_n = 1'b1;
        cyc = 0;
        intr_in = 32'h4;
        tick();
        intr_in = '0;
        chk_head("post_rst", 32'h4, 32'd0);
        tick_to(3);
        intr_in = 32'h4;
        tick();
        intr_in = '0;
        chk("post_rst_level", 64'(fifo_level), 64'(2));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
